// File: rtl/mem_split_ctrl_if.sv
// Memory-stage to data-memory bus for mem_split_ctrl: pipeline request,
// control, memory handshake and status signals.
interface mem_split_if #(
  parameter int COUNT_W = 16
);
  logic               halt;
  logic               flush;
  logic               req_valid;
  logic [4:0]         opcode;
  logic               is_load;
  logic               is_store;
  logic [31:0]        addr;
  logic [31:0]        store_data;
  logic               mem_gnt;
  logic               mem_req;
  logic [31:0]        mem_addr;
  logic [3:0]         mem_we;
  logic [31:0]        mem_wdata;
  logic               stall;
  logic               is_misaligned_out;
  logic [COUNT_W-1:0] split_count;

  modport master (
    output halt, flush, req_valid, opcode, is_load, is_store, addr, store_data, mem_gnt,
    input  mem_req, mem_addr, mem_we, mem_wdata, stall, is_misaligned_out, split_count
  );

  modport slave (
    input  halt, flush, req_valid, opcode, is_load, is_store, addr, store_data, mem_gnt,
    output mem_req, mem_addr, mem_we, mem_wdata, stall, is_misaligned_out, split_count
  );
endinterface

// File: rtl/mem_split_ctrl.sv
// Memory-stage access sequencer: decodes size, builds byte lanes and splits
// word-crossing accesses into two back-to-back word accesses.
module mem_split_ctrl #(
  parameter int COUNT_W = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_split_if.slave  bus
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t               state_q, state_d;
  logic [31:0]          sec_addr_q, sec_addr_d;
  logic [31:0]          sec_wdata_q, sec_wdata_d;
  logic [3:0]           sec_we_q, sec_we_d;
  logic                 sec_load_q, sec_load_d;
  logic                 mis_q, mis_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;

  logic        is_word, is_half, is_byte, active, split;
  logic [1:0]  off;
  logic [4:0]  sh;
  logic [31:0] base;
  logic [3:0]  we1, we2;
  logic [31:0] wd1, wd2;

  logic        req;
  logic [31:0] maddr, mwdata;
  logic [3:0]  mwe;
  logic        stl;

  always_comb begin
    off     = bus.addr[1:0];
    sh      = {off, 3'b000};
    base    = {bus.addr[31:2], 2'b00};
    is_word = (bus.opcode >= 5'd3) && (bus.opcode <= 5'd5);
    is_half = (bus.opcode >= 5'd6) && (bus.opcode <= 5'd8);
    is_byte = (bus.opcode >= 5'd9) && (bus.opcode <= 5'd11);
    active  = bus.req_valid && (bus.is_load || bus.is_store) && (is_word || is_half || is_byte);
    split   = (is_word && (off != 2'd0)) || (is_half && (off == 2'd3));

    we1 = 4'b0000;
    we2 = 4'b0000;
    wd1 = 32'd0;
    wd2 = 32'd0;
    if (bus.is_store) begin
      if (is_word)      we1 = 4'b1111 << off;
      else if (is_half) we1 = 4'b0011 << off;
      else              we1 = 4'b0001 << off;
      // Only a word or an offset-3 half reaches the second word.
      we2 = is_word ? (4'b1111 >> (3'd4 - {1'b0, off})) : 4'b0001;
      wd1 = bus.store_data << sh;
      wd2 = bus.store_data >> (6'd32 - {1'b0, sh});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sec_addr_q  <= '0;
      sec_wdata_q <= '0;
      sec_we_q    <= '0;
      sec_load_q  <= 1'b0;
      mis_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sec_addr_q  <= sec_addr_d;
      sec_wdata_q <= sec_wdata_d;
      sec_we_q    <= sec_we_d;
      sec_load_q  <= sec_load_d;
      mis_q       <= mis_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sec_addr_d  = sec_addr_q;
    sec_wdata_d = sec_wdata_q;
    sec_we_d    = sec_we_q;
    sec_load_d  = sec_load_q;
    mis_d       = 1'b0;
    cnt_d       = cnt_q;
    req         = 1'b0;
    maddr       = 32'd0;
    mwe         = 4'b0000;
    mwdata      = 32'd0;
    stl         = 1'b0;

    if (bus.halt) begin
      // Frozen: keep presenting the pending access fields but never request.
      mis_d = mis_q;
      if (state_q == SECOND) begin
        maddr  = sec_addr_q;
        mwe    = sec_we_q;
        mwdata = sec_wdata_q;
        stl    = 1'b1;
      end else if (active && !bus.flush) begin
        maddr  = base;
        mwe    = we1;
        mwdata = wd1;
        stl    = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (active && !bus.flush) begin
            req    = 1'b1;
            maddr  = base;
            mwe    = we1;
            mwdata = wd1;
            stl    = !bus.mem_gnt || split;
            if (bus.mem_gnt && split) begin
              state_d     = SECOND;
              sec_addr_d  = base + 32'd4;
              sec_we_d    = we2;
              sec_wdata_d = wd2;
              sec_load_d  = bus.is_load;
            end
          end
        end
        SECOND: begin
          if (bus.flush) begin
            state_d = IDLE;
          end else begin
            req    = 1'b1;
            maddr  = sec_addr_q;
            mwe    = sec_we_q;
            mwdata = sec_wdata_q;
            stl    = !bus.mem_gnt;
            if (bus.mem_gnt) begin
              state_d = IDLE;
              mis_d   = sec_load_q;
              if (cnt_q != {COUNT_W{1'b1}}) cnt_d = cnt_q + COUNT_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.mem_req           = req;
  assign bus.mem_addr          = maddr;
  assign bus.mem_we            = mwe;
  assign bus.mem_wdata         = mwdata;
  assign bus.stall             = stl;
  assign bus.is_misaligned_out = mis_q;
  assign bus.split_count       = cnt_q;

endmodule
